// File: rtl/lane_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// lane_pingpong_ctrl
//
// Sequences the two note-lane RAMs as a ping-pong pair. The y-position
// producer fills the back buffer (index ~front_sel) while the VGA renderer
// reads the front buffer (index front_sel). The buffers swap only on a frame
// boundary, and only once the back buffer holds all DEPTH entries.
//
// Ports
//   clk, resetn              clock (rising edge), synchronous active-low reset
//   frame_start              one-cycle pulse at the VGA frame boundary
//   wr_valid/wr_data/wr_ready producer handshake into the back buffer
//   rd_req/rd_addr           renderer read request against the front buffer
//   rd_valid/rd_data         read response, one cycle after rd_req
//   ram0_*/ram1_*            ports of the two sync-read (1-cycle) RAMs
//   front_sel                buffer currently displayed
//   back_full                back buffer complete, waiting for a swap
//   late_frames              saturating count of frames that found the
//                            back buffer incomplete
// ---------------------------------------------------------------------------
module lane_pingpong_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              frame_start,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              ram0_we,
    output logic [ADDR_W-1:0] ram0_addr,
    output logic [DATA_W-1:0] ram0_wdata,
    input  logic [DATA_W-1:0] ram0_rdata,
    output logic              ram1_we,
    output logic [ADDR_W-1:0] ram1_addr,
    output logic [DATA_W-1:0] ram1_wdata,
    input  logic [DATA_W-1:0] ram1_rdata,
    output logic              front_sel,
    output logic              back_full,
    output logic [7:0]        late_frames
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state_q,     state_d;
    logic                front_sel_q, front_sel_d;
    logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [7:0]          late_q,      late_d;
    logic                rd_valid_q,  rd_valid_d;
    logic                rd_sel_q,    rd_sel_d;
    logic [DATA_W-1:0]   rd_hold_q,   rd_hold_d;

    logic                wr_accept;
    logic                last_write;
    logic [DATA_W-1:0]   rd_mux;

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        wr_ptr_d    = wr_ptr_q;
        late_d      = late_q;

        // Writes are suppressed while reset is asserted so no RAM is
        // disturbed during the reset cycle.
        wr_accept  = resetn && (state_q == FILL) && wr_valid;
        last_write = wr_accept && (wr_ptr_q == '1);

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (last_write) begin
            state_d = FULL;
        end

        // A frame boundary swaps when the back buffer is complete, including
        // the case where the final entry lands in this very cycle.
        if (frame_start) begin
            if ((state_q == FULL) || last_write) begin
                front_sel_d = ~front_sel_q;
                state_d     = FILL;
                wr_ptr_d    = '0;
            end else if (late_q != 8'hFF) begin
                late_d = late_q + 8'd1;
            end
        end

        // Remember which RAM the request addressed so a request issued in
        // the swap cycle still returns data from the pre-swap front buffer.
        rd_valid_d = rd_req;
        rd_sel_d   = front_sel_q;
        rd_mux     = rd_sel_q ? ram1_rdata : ram0_rdata;
        rd_hold_d  = rd_valid_q ? rd_mux : rd_hold_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= FILL;
            front_sel_q <= 1'b0;
            wr_ptr_q    <= '0;
            late_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_sel_q    <= 1'b0;
            rd_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            wr_ptr_q    <= wr_ptr_d;
            late_q      <= late_d;
            rd_valid_q  <= rd_valid_d;
            rd_sel_q    <= rd_sel_d;
            rd_hold_q   <= rd_hold_d;
        end
    end

    // The back RAM carries the write pointer, the front RAM carries the
    // renderer address; the two roles never overlap in one cycle.
    always_comb begin
        ram0_we    = wr_accept &&  front_sel_q;
        ram1_we    = wr_accept && !front_sel_q;
        ram0_addr  = front_sel_q ? wr_ptr_q : rd_addr;
        ram1_addr  = front_sel_q ? rd_addr  : wr_ptr_q;
        ram0_wdata = wr_data;
        ram1_wdata = wr_data;
    end

    assign wr_ready    = (state_q == FILL);
    assign back_full   = (state_q == FULL);
    assign front_sel   = front_sel_q;
    assign late_frames = late_q;
    assign rd_valid    = rd_valid_q;
    // The RAM output is only valid in the response cycle; otherwise the
    // last response is held.
    assign rd_data     = rd_valid_q ? rd_mux : rd_hold_q;

endmodule

// File: tb/tb_lane_pingpong_ctrl.sv
module tb_lane_pingpong_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       frame_start;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic [3:0] rd_addr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       ram0_we, ram1_we;
    logic [3:0] ram0_addr, ram1_addr;
    logic [7:0] ram0_wdata, ram1_wdata;
    logic [7:0] ram0_rdata, ram1_rdata;
    logic       front_sel;
    logic       back_full;
    logic [7:0] late_frames;

    always #5 clk = ~clk;

    lane_pingpong_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .resetn(resetn), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .ram0_we(ram0_we), .ram0_addr(ram0_addr), .ram0_wdata(ram0_wdata), .ram0_rdata(ram0_rdata),
        .ram1_we(ram1_we), .ram1_addr(ram1_addr), .ram1_wdata(ram1_wdata), .ram1_rdata(ram1_rdata),
        .front_sel(front_sel), .back_full(back_full), .late_frames(late_frames)
    );

    // Two sync-read RAMs, read-before-write, 1-cycle latency.
    logic [7:0] mem0 [16];
    logic [7:0] mem1 [16];
    initial begin
        for (int i = 0; i < 16; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
    end
    always @(posedge clk) begin
        ram0_rdata <= mem0[ram0_addr];
        ram1_rdata <= mem1[ram1_addr];
        if (ram0_we) mem0[ram0_addr] <= ram0_wdata;
        if (ram1_we) mem1[ram1_addr] <= ram1_wdata;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: buffer contents, how many entries the back buffer
    // holds, which buffer is displayed, and the late-frame tally.
    logic [7:0] mbuf [2][16];
    int         m_front = 0;
    int         m_cnt   = 0;
    int         m_late  = 0;
    bit         m_pend  = 1'b0;
    logic [7:0] m_pend_val = 8'h00;
    logic [7:0] m_last     = 8'h00;

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++)
                mbuf[b][i] = 8'h00;
    end

    task automatic cycle(input bit rn, input bit fs, input bit wv, input logic [7:0] wd,
                         input bit rq, input logic [3:0] ra);
        bit acc;
        int back;
        @(negedge clk);
        resetn      = rn;
        frame_start = fs;
        wr_valid    = wv;
        wr_data     = wd;
        rd_req      = rq;
        rd_addr     = ra;
        #1;
        acc  = rn && (m_cnt < 16) && wv;
        back = 1 - m_front;
        check("wr_ready",    32'(wr_ready),    32'(m_cnt < 16));
        check("back_full",   32'(back_full),   32'(m_cnt == 16));
        check("front_sel",   32'(front_sel),   32'(m_front));
        check("late_frames", 32'(late_frames), 32'(m_late));
        check("rd_valid",    32'(rd_valid),    32'(m_pend));
        check("rd_data",     32'(rd_data),     32'(m_pend ? m_pend_val : m_last));
        check("ram0_we",     32'(ram0_we),     32'(acc && back == 0));
        check("ram1_we",     32'(ram1_we),     32'(acc && back == 1));
        if (back == 0) begin
            check("front_addr", 32'(ram1_addr), 32'(ra));
            if (acc) begin
                check("wr_addr",  32'(ram0_addr),  32'(m_cnt));
                check("wr_wdata", 32'(ram0_wdata), 32'(wd));
            end
        end else begin
            check("front_addr", 32'(ram0_addr), 32'(ra));
            if (acc) begin
                check("wr_addr",  32'(ram1_addr),  32'(m_cnt));
                check("wr_wdata", 32'(ram1_wdata), 32'(wd));
            end
        end
        if (!rn) begin
            m_front = 0;
            m_cnt   = 0;
            m_late  = 0;
            m_pend  = 1'b0;
            m_last  = 8'h00;
        end else begin
            if (m_pend) m_last = m_pend_val;
            m_pend     = rq;
            m_pend_val = mbuf[m_front][ra];
            if (acc) begin
                mbuf[back][m_cnt] = wd;
                m_cnt++;
            end
            if (fs) begin
                if (m_cnt == 16) begin
                    m_front = back;
                    m_cnt   = 0;
                end else if (m_late < 255) begin
                    m_late++;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 8'h00, 0, 4'h0);
    endtask

    task automatic write_n(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) cycle(1, 0, 1, base + 8'(i), 0, 4'h0);
    endtask

    initial begin
        resetn = 1'b0; frame_start = 1'b0; wr_valid = 1'b0;
        wr_data = 8'h00; rd_req = 1'b0; rd_addr = 4'h0;
        repeat (2) @(posedge clk);

        // Reset state.
        cycle(0, 0, 0, 8'h00, 0, 4'h0);
        idle(1);

        // Fill buffer 1 with 0x10..0x1F, then the producer stalls.
        write_n(16, 8'h10);
        for (int i = 0; i < 2; i++) cycle(1, 0, 1, 8'hEE, 0, 4'h0);

        // Swap, then read entry 5 of the new front buffer.
        cycle(1, 1, 0, 8'h00, 0, 4'h0);
        cycle(1, 0, 0, 8'h00, 1, 4'h5);
        idle(1);
        check("t2_rd_data", 32'(rd_data), 32'h15);
        idle(1);

        // Late frame on a partial fill, then completion without a swap.
        write_n(7, 8'h20);
        cycle(1, 1, 0, 8'h00, 0, 4'h0);
        write_n(9, 8'h27);
        idle(3);
        cycle(1, 1, 0, 8'h00, 0, 4'h0);

        // Frame boundary coincident with the final write, plus a read in the
        // swap cycle that must come from the pre-swap front buffer.
        write_n(15, 8'h40);
        cycle(1, 1, 1, 8'h4F, 1, 4'h3);
        cycle(1, 0, 1, 8'h50, 0, 4'h0);
        idle(1);

        // Reset mid-fill at wr_ptr=9 with a read in flight.
        write_n(8, 8'h51);
        cycle(0, 1, 1, 8'h99, 1, 4'h2);
        idle(1);
        cycle(1, 0, 1, 8'h60, 0, 4'h0);

        // Saturation of the late-frame counter.
        for (int i = 0; i < 300; i++) cycle(1, 1, 0, 8'h00, 0, 4'h0);
        check("late_sat", 32'(late_frames), 32'd255);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(199) != 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(3) != 0),
                  8'($urandom),
                  ($urandom_range(1) == 1),
                  4'($urandom));
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
